// File: rtl/mcpu_datapath.sv
// ---------------------------------------------------------------------------
// mcpu_datapath
//   Single-clock MCPU execution datapath. It contains:
//   - a 16x8 register file with three combinational read ports
//     (op1/op2/op3) and one synchronous write port addressed by op1;
//   - a 2-bit-command 8-bit ALU (AND/OR/XOR/ADD with carry);
//   - a 256x8 RAM with one read/write data port and one always-enabled
//     instruction read port.
//   An external sequencer drives every command and strobe. This block does
//   no sequencing of its own.
//
// Ports
//   clk, rst_n                clock, asynchronous active-low reset
//   op1, op2, op3             register selectors (dest/store-src, ALU A, ALU B)
//   regsetcmd, regsetwb       register-file command and write-back enable
//   datatoload                external register write data
//   alucmd                    ALU operation
//   we, re, addr, datawr      RAM data port
//   instraddr                 RAM instruction port address
//   RegOp1, alu1, alu2        reg[op1], reg[op2], reg[op3]
//   alu_out, cf               ALU result and carry
//   datard, instrrd           RAM data-port and instruction-port read data
//   zf                        zero flag (only with MCPU_DATAPATH_ZF_EN)
//
// Optional feature
//   `define MCPU_DATAPATH_ZF_EN adds the zf output, high when alu_out == 0.
// ---------------------------------------------------------------------------
module mcpu_datapath #(
  parameter int WORD_SIZE         = 8,
  parameter int ADDR_WIDTH        = 8,
  parameter int OPERAND_SIZE      = 4,
  parameter int REGS_NUMBER_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPERAND_SIZE-1:0] op1,
  input  logic [OPERAND_SIZE-1:0] op2,
  input  logic [OPERAND_SIZE-1:0] op3,
  input  logic [1:0]              regsetcmd,
  input  logic                    regsetwb,
  input  logic [WORD_SIZE-1:0]    datatoload,
  input  logic [1:0]              alucmd,
  input  logic                    we,
  input  logic                    re,
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [WORD_SIZE-1:0]    datawr,
  input  logic [ADDR_WIDTH-1:0]   instraddr,
  output logic [WORD_SIZE-1:0]    RegOp1,
  output logic [WORD_SIZE-1:0]    alu1,
  output logic [WORD_SIZE-1:0]    alu2,
  output logic [WORD_SIZE-1:0]    alu_out,
  output logic                    cf,
  output logic [WORD_SIZE-1:0]    datard,
`ifdef MCPU_DATAPATH_ZF_EN
  output logic [WORD_SIZE-1:0]    instrrd,
  output logic                    zf
`else
  output logic [WORD_SIZE-1:0]    instrrd
`endif
);

  localparam int REGS  = 1 << REGS_NUMBER_WIDTH;
  localparam int WORDS = 1 << ADDR_WIDTH;

  localparam logic [1:0] RS_NORMAL = 2'b00;
  localparam logic [1:0] RS_MOV    = 2'b01;
  localparam logic [1:0] RS_LOAD   = 2'b10;
  localparam logic [1:0] RS_STORE  = 2'b11;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b11;

  logic [WORD_SIZE-1:0] regs_q [REGS];
  logic [WORD_SIZE-1:0] mem_q  [WORDS];

  // Only the low REGS_NUMBER_WIDTH bits of a selector address the file.
  logic [REGS_NUMBER_WIDTH-1:0] sel1, sel2, sel3;
  assign sel1 = op1[REGS_NUMBER_WIDTH-1:0];
  assign sel2 = op2[REGS_NUMBER_WIDTH-1:0];
  assign sel3 = op3[REGS_NUMBER_WIDTH-1:0];

  // Register file read side
  assign RegOp1 = regs_q[sel1];
  assign alu1   = regs_q[sel2];
  assign alu2   = regs_q[sel3];

  // Register file write side: MOV takes the pre-edge value of reg[op2], so
  // a MOV onto itself rewrites the same value.
  logic                 reg_we_d;
  logic [WORD_SIZE-1:0] reg_wdata_d;

  always_comb begin
    reg_we_d    = 1'b0;
    reg_wdata_d = datatoload;
    unique case (regsetcmd)
      RS_NORMAL: reg_we_d = regsetwb;
      RS_MOV: begin
        reg_we_d    = regsetwb;
        reg_wdata_d = alu1;
      end
      RS_LOAD:   reg_we_d = regsetwb;
      RS_STORE:  reg_we_d = 1'b0;
      default:   reg_we_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REGS; i++) regs_q[i] <= '0;
    end else if (reg_we_d) begin
      regs_q[sel1] <= reg_wdata_d;
    end
  end

  // ALU
  logic [WORD_SIZE:0] sum;
  assign sum = {1'b0, alu1} + {1'b0, alu2};

  always_comb begin
    alu_out = '0;
    cf      = 1'b0;
    unique case (alucmd)
      ALU_AND: alu_out = alu1 & alu2;
      ALU_OR:  alu_out = alu1 | alu2;
      ALU_XOR: alu_out = alu1 ^ alu2;
      ALU_ADD: begin
        alu_out = sum[WORD_SIZE-1:0];
        cf      = sum[WORD_SIZE];
      end
      default: alu_out = '0;
    endcase
  end

`ifdef MCPU_DATAPATH_ZF_EN
  assign zf = (alu_out == '0);
`endif

  // RAM: reset clears every word, so it is built from flops, not a macro.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
    end else if (we) begin
      mem_q[addr] <= datawr;
    end
  end

  assign datard  = re ? mem_q[addr] : '0;
  assign instrrd = mem_q[instraddr];

endmodule

// File: tb/tb_mcpu_datapath.sv
`timescale 1ns/100ps
module tb_mcpu_datapath;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] op1, op2, op3;
  logic [1:0] regsetcmd;
  logic       regsetwb;
  logic [7:0] datatoload;
  logic [1:0] alucmd;
  logic       we, re;
  logic [7:0] addr, datawr, instraddr;
  logic [7:0] RegOp1, alu1, alu2, alu_out, datard, instrrd;
  logic       cf;
`ifdef MCPU_DATAPATH_ZF_EN
  logic       zf;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  mcpu_datapath dut (
    .clk(clk), .rst_n(rst_n),
    .op1(op1), .op2(op2), .op3(op3),
    .regsetcmd(regsetcmd), .regsetwb(regsetwb), .datatoload(datatoload),
    .alucmd(alucmd), .we(we), .re(re), .addr(addr), .datawr(datawr),
    .instraddr(instraddr),
    .RegOp1(RegOp1), .alu1(alu1), .alu2(alu2), .alu_out(alu_out), .cf(cf),
    .datard(datard),
`ifdef MCPU_DATAPATH_ZF_EN
    .instrrd(instrrd), .zf(zf)
`else
    .instrrd(instrrd)
`endif
  );

  always #10 clk = ~clk;

  // Reference model: architectural state as plain arrays
  logic [7:0] mregs [16];
  logic [7:0] mmem  [256];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)  mregs[i] <= 8'd0;
      for (int i = 0; i < 256; i++) mmem[i]  <= 8'd0;
    end else begin
      if (regsetwb && regsetcmd != 2'b11)
        mregs[op1] <= (regsetcmd == 2'b01) ? mregs[op2] : datatoload;
      if (we) mmem[addr] <= datawr;
    end
  end

  function automatic logic [8:0] model_alu(input int a, input int b, input logic [1:0] c);
    int s;
    case (c)
      2'b00:   s = a & b;
      2'b01:   s = a | b;
      2'b10:   s = a ^ b;
      default: s = a + b;
    endcase
    return {1'(s > 255), 8'(s % 256)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every output against the model, mid-cycle
  logic [8:0] exp_alu;
  always @(negedge clk) begin
    if (chk_en) begin
      exp_alu = model_alu(int'(mregs[op2]), int'(mregs[op3]), alucmd);
      chk("m_RegOp1",  32'(RegOp1),  32'(mregs[op1]));
      chk("m_alu1",    32'(alu1),    32'(mregs[op2]));
      chk("m_alu2",    32'(alu2),    32'(mregs[op3]));
      chk("m_alu_out", 32'(alu_out), 32'(exp_alu[7:0]));
      chk("m_cf",      32'(cf),      32'(exp_alu[8]));
      chk("m_datard",  32'(datard),  re ? 32'(mmem[addr]) : 32'd0);
      chk("m_instrrd", 32'(instrrd), 32'(mmem[instraddr]));
`ifdef MCPU_DATAPATH_ZF_EN
      chk("m_zf",      32'(zf),      32'(exp_alu[7:0] == 8'd0));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regsetwb = 1'b0; we = 1'b0; re = 1'b0;
    regsetcmd = 2'b00; alucmd = 2'b00;
  endtask

  task automatic load(input logic [3:0] r, input logic [7:0] v);
    op1 = r; datatoload = v; regsetcmd = 2'b10; regsetwb = 1'b1;
    tick();
    regsetwb = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      op1 = 4'($urandom); op2 = 4'($urandom); op3 = 4'($urandom);
      regsetcmd = 2'($urandom); regsetwb = 1'($urandom);
      datatoload = 8'($urandom); alucmd = 2'($urandom);
      we = ($urandom_range(0, 2) != 0); re = 1'($urandom);
      // Bias some addresses into a small window to force reuse
      addr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      instraddr = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      datawr = 8'($urandom);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    op1 = 0; op2 = 0; op3 = 0; datatoload = 0; addr = 0; datawr = 0; instraddr = 0;
    idle();
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick();

    // Random traffic fills registers and RAM with arbitrary data
    rand_cycles(200);

    // Mid-cycle asynchronous reset
    idle();
    we = 1'b1; datawr = 8'hFF; addr = 8'd3;
    #2 rst_n = 1'b0;
    #1;
    we = 1'b0; re = 1'b1; alucmd = 2'b11;
    for (int i = 0; i < 16; i++) begin
      op1 = 4'(i); op2 = 4'(i); op3 = 4'(15 - i);
      addr = 8'($urandom); instraddr = 8'(i * 16 + 3);
      #1;
      chk("rst_RegOp1",  32'(RegOp1),  0);
      chk("rst_alu1",    32'(alu1),    0);
      chk("rst_alu2",    32'(alu2),    0);
      chk("rst_alu_out", 32'(alu_out), 0);
      chk("rst_cf",      32'(cf),      0);
      chk("rst_datard",  32'(datard),  0);
      chk("rst_instrrd", 32'(instrrd), 0);
      tick();
    end
    rst_n = 1'b1;
    idle();
    tick();

    // LOAD_FROM_DATA, then STORE_TO_MEM must not write
    load(4'd0, 8'd46);
    load(4'd1, 8'd54);
    op1 = 4'd0; #1 chk("ld_r0", 32'(RegOp1), 46);
    op1 = 4'd1; #1 chk("ld_r1", 32'(RegOp1), 54);
    op1 = 4'd0; datatoload = 8'd99; regsetcmd = 2'b11; regsetwb = 1'b1;
    tick();
    op1 = 4'd1; tick();
    regsetwb = 1'b0;
    op1 = 4'd0; #1 chk("st_r0", 32'(RegOp1), 46);
    op1 = 4'd1; #1 chk("st_r1", 32'(RegOp1), 54);
    tick();

    // Store/load round trip through RAM
    op1 = 4'd0; #1 datawr = RegOp1; addr = 8'd100; we = 1'b1;
    tick();
    op1 = 4'd1; #1 datawr = RegOp1; addr = 8'd101;
    tick();
    we = 1'b0; re = 1'b1; addr = 8'd100;
    #1 datatoload = datard; regsetcmd = 2'b00; op1 = 4'd2; regsetwb = 1'b1;
    tick();
    addr = 8'd101;
    #1 datatoload = datard; op1 = 4'd3;
    tick();
    regsetwb = 1'b0;
    op1 = 4'd2; #1 chk("rt_r2", 32'(RegOp1), 46);
    op1 = 4'd3; #1 chk("rt_r3", 32'(RegOp1), 54);
    instraddr = 8'd101; #1 chk("rt_instr", 32'(instrrd), 54);
    re = 1'b0; #1 chk("rt_re0", 32'(datard), 0);
    tick();

    // ALU operations on reg2=46, reg3=54
    op2 = 4'd2; op3 = 4'd3; alucmd = 2'b11;
    #1 chk("add", 32'(alu_out), 100);
    chk("add_cf", 32'(cf), 0);
    datatoload = alu_out; op1 = 4'd4; regsetcmd = 2'b00; regsetwb = 1'b1;
    tick();
    regsetwb = 1'b0; alucmd = 2'b10;
    #1 chk("xor", 32'(alu_out), 24);
    datatoload = alu_out; op1 = 4'd5; regsetwb = 1'b1;
    tick();
    regsetwb = 1'b0;
    op1 = 4'd4; #1 chk("wb_r4", 32'(RegOp1), 100);
    op1 = 4'd5; #1 chk("wb_r5", 32'(RegOp1), 24);
    alucmd = 2'b00; #1 chk("and", 32'(alu_out), 38);
    alucmd = 2'b01; #1 chk("or",  32'(alu_out), 62);
    chk("or_cf", 32'(cf), 0);
    tick();

    // Carry cases
    load(4'd7, 8'd200);
    op2 = 4'd7; op3 = 4'd4; alucmd = 2'b11;
    #1 chk("c_sum", 32'(alu_out), 44);
    chk("c_cf", 32'(cf), 1);
    load(4'd8, 8'd255);
    load(4'd9, 8'd1);
    op2 = 4'd8; op3 = 4'd9; alucmd = 2'b11;
    #1 chk("wrap_sum", 32'(alu_out), 0);
    chk("wrap_cf", 32'(cf), 1);
`ifdef MCPU_DATAPATH_ZF_EN
    chk("wrap_zf", 32'(zf), 1);
    alucmd = 2'b01; #1 chk("or_zf", 32'(zf), 0);
`endif
    tick();

    // MOV_INTERNAL, including the same-register case
    op1 = 4'd6; op2 = 4'd4; regsetcmd = 2'b01; regsetwb = 1'b1;
    #1 chk("mov_pre", 32'(RegOp1), 0);
    tick();
    regsetwb = 1'b0;
    #1 chk("mov_post", 32'(RegOp1), 100);
    op1 = 4'd4; op2 = 4'd4; regsetwb = 1'b1;
    tick();
    regsetwb = 1'b0;
    #1 chk("mov_self", 32'(RegOp1), 100);

    // Register read-during-write
    op1 = 4'd10; datatoload = 8'd77; regsetcmd = 2'b10; regsetwb = 1'b1;
    #1 chk("rdw_reg_pre", 32'(RegOp1), 0);
    tick();
    regsetwb = 1'b0;
    #1 chk("rdw_reg_post", 32'(RegOp1), 77);

    // RAM read-during-write on the same address, both ports
    addr = 8'd50; instraddr = 8'd50; datawr = 8'hA5; we = 1'b1; re = 1'b1;
    #1 chk("rdw_ram_pre", 32'(datard), 0);
    chk("rdw_ins_pre", 32'(instrrd), 0);
    tick();
    datawr = 8'h3C;
    #1 chk("rdw_ram_mid", 32'(datard), 32'h A5);
    chk("rdw_ins_mid", 32'(instrrd), 32'h A5);
    tick();
    we = 1'b0;
    #1 chk("rdw_ram_post", 32'(datard), 32'h3C);
    tick();

    // More random traffic against the model
    rand_cycles(400);

    idle();
    tick();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mcpu_datapath.md
Name: mcpu_datapath

Overview:
Single-clock MCPU execution datapath. It combines a 16x8 register file with three read ports, a 2-bit-command 8-bit ALU, and a 256x8 RAM controller with one data port and one instruction read port. Sequencer logic drives all register-file commands, ALU commands and memory strobes; the block itself has no sequencing. Register-file write data is taken from the external datatoload bus, which the sequencer drives from datard or alu_out.

Parameters:
WORD_SIZE, 8, data width of registers, ALU and RAM words
ADDR_WIDTH, 8, RAM address width (2^ADDR_WIDTH words)
OPERAND_SIZE, 4, width of op1/op2/op3 register selectors
REGS_NUMBER_WIDTH, 4, log2 of register count (16 registers)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
op1  in  OPERAND_SIZE  destination / store-source register select
op2  in  OPERAND_SIZE  ALU operand A register select
op3  in  OPERAND_SIZE  ALU operand B register select
regsetcmd  in  2  register-file command
regsetwb  in  1  register write-back enable
datatoload  in  WORD_SIZE  external write data for the register file
alucmd  in  2  ALU operation
we  in  1  RAM write enable
re  in  1  RAM data-port read enable
addr  in  ADDR_WIDTH  RAM data-port address
datawr  in  WORD_SIZE  RAM write data
instraddr  in  ADDR_WIDTH  instruction-port address
RegOp1  out  WORD_SIZE  reg[op1]
alu1  out  WORD_SIZE  reg[op2]
alu2  out  WORD_SIZE  reg[op3]
alu_out  out  WORD_SIZE  ALU result
cf  out  1  ALU carry flag
datard  out  WORD_SIZE  RAM data-port read data
instrrd  out  WORD_SIZE  RAM instruction read data

Behaviour:
- Reset: while rst_n=0, all 16 registers and all 256 RAM words are cleared to 0, so every output reads 0. Reset takes effect immediately, including mid-write.
- Register file, read side: RegOp1, alu1 and alu2 are combinational reads of reg[op1], reg[op2] and reg[op3].
  - Selectors wider than REGS_NUMBER_WIDTH use only their low REGS_NUMBER_WIDTH bits.
- Register file, write side: writes happen on the rising clk edge when regsetwb=1, to reg[op1]. Source by regsetcmd:
  - 00 NORMAL_EX/LOAD_FROM_MEM: write datatoload.
  - 01 MOV_INTERNAL: write reg[op2]. The value is sampled before the edge, so op1=op2 leaves the register unchanged.
  - 10 LOAD_FROM_DATA: write datatoload.
  - 11 STORE_TO_MEM: no register write; RegOp1 only presents the source value.
- Read-during-write: a read of the register being written returns the old value until the edge and the new value afterwards.
- ALU (combinational, in1=alu1, in2=alu2):
  - 00 AND, cf=0.
  - 01 OR, cf=0.
  - 10 XOR, cf=0.
  - 11 ADD: alu_out = (in1+in2) mod 256, cf = bit 8 of the 9-bit sum.
- RAM data port:
  - Write: synchronous on rising clk when we=1, mem[addr] <= datawr.
  - Read: datard = re ? mem[addr] : 0, combinational.
  - we=1 and re=1 on the same address: datard shows the old contents until the edge, then the new data.
- RAM instruction port: instrrd = mem[instraddr], always enabled, combinational. It sees writes after the write edge.
- Address wrap: addr and instraddr are ADDR_WIDTH bits and cannot exceed the array; no out-of-range case exists.
- Single-cycle latency for all writes; zero latency for all reads.

Optional Feature:
- Macro MCPU_DATAPATH_ZF_EN.
- When defined: adds output port zf (1 bit), combinational, high when alu_out==0 for any alucmd.
- When undefined: port zf is absent and there is no zero-detect logic.

Test Plan:
- Reset: assert rst_n=0 after writing arbitrary data, then release -> all registers, RAM words, RegOp1, alu1, alu2, datard and instrrd read 0; alu_out=0 and cf=0 under ADD.
- LOAD_FROM_DATA: regsetcmd=10, datatoload=46, op1=0, regsetwb=1 for one edge; then datatoload=54, op1=1 -> RegOp1 reads 46 for op1=0 and 54 for op1=1; regsetcmd=11 with regsetwb=1 leaves both unchanged.
- Store/load round trip: datawr=RegOp1 (46) at addr 100 with we=1, then 54 at addr 101. Then we=0, re=1, addr=100, datatoload=datard, regsetcmd=00, op1=2, followed by addr=101, op1=3 -> reg2=46, reg3=54; instrrd with instraddr=101 returns 54; re=0 forces datard=0.
- ALU: op2=2, op3=3. alucmd=11 -> alu_out=100, cf=0; write to reg4 via datatoload=alu_out. alucmd=10 -> alu_out=24; write to reg5. alucmd=00 -> 38. alucmd=01 -> 62.
- Carry: registers holding 200 and 100, alucmd=11 -> alu_out=44, cf=1; 255+1 -> 0, cf=1 (zf=1 when MCPU_DATAPATH_ZF_EN is defined).
- MOV_INTERNAL and hazards: regsetcmd=01, op1=6, op2=4 -> reg6=100 after the edge. Same-edge RAM write with read at the same address -> datard shows the old value before the edge and the new value after it.
